// File: rtl/axi_xact_arb.sv
// axi_xact_arb: round-robin arbiter that pops transactions from NUM_REQ
// requesters, offers them one at a time to a packet checker, and tracks
// issued-but-uncompared transactions in an in-order FIFO so each compare
// completion is routed back to the requester that originated it.
module axi_xact_arb #(
    parameter int NUM_REQ         = 2,
    parameter int TGT_ADDR_WIDTH  = 28,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_REQ-1:0]                i_req_avail,
    input  logic [NUM_REQ*TGT_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*8-1:0]              i_req_len,
    output logic [NUM_REQ-1:0]                o_req_read,
    output logic                              o_xact_avail,
    input  logic                              i_xact_read,
    output logic [TGT_ADDR_WIDTH-1:0]         o_xact_addr,
    output logic [7:0]                        o_xact_len,
    input  logic                              i_pkt_compared,
    output logic [NUM_REQ-1:0]                o_req_done,
    output logic [3:0]                        o_outstanding,
    output logic                              o_underflow
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_OFFER = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [IDXW-1:0]           grant_q, grant_d;
    logic [IDXW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [TGT_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [3:0]                count_q, count_d;
    logic [NUM_REQ-1:0]        done_q, done_d;
    logic                      underflow_q;

    // Order FIFO storage is sized to a power of two so any pointer value
    // indexes a real entry; pointers still wrap at MAX_OUTSTANDING.
    logic [IDXW-1:0]           fifo_q [2**PTRW];
    logic [PTRW-1:0]           wr_ptr_q, rd_ptr_q;

    logic                      gnt_found;
    logic [IDXW-1:0]           gnt_idx;
    logic [IDXW:0]             cand;

    logic                      accept;
    logic                      cnt_zero;
    logic                      pop;
    logic                      fifo_wr;
    logic                      fifo_rd;
    logic [IDXW-1:0]           pop_idx;
    logic                      underflow_set;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting at rr_ptr_q; first available requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NUM_REQ))
                cand = cand - (IDXW+1)'(NUM_REQ);
            if (!gnt_found && i_req_avail[cand[IDXW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDXW-1:0];
            end
        end
    end

    // Main sequencer: IDLE grants (gated on outstanding limit), then one
    // cycle each of FETCH and LOAD, then OFFER until the checker accepts.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found && (count_q < 4'(MAX_OUTSTANDING))) begin
                    state_d  = S_FETCH;
                    grant_d  = gnt_idx;
                    rr_ptr_d = (gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_OFFER;
            S_OFFER: if (i_xact_read) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Accept only counts in OFFER. A compare arriving with an empty FIFO
    // alongside an accept completes the just-accepted transaction directly.
    assign accept        = (state_q == S_OFFER) && i_xact_read;
    assign cnt_zero      = (count_q == 4'd0);
    assign pop           = i_pkt_compared && (!cnt_zero || accept);
    assign fifo_wr       = accept && !(pop && cnt_zero);
    assign fifo_rd       = pop && !cnt_zero;
    assign pop_idx       = cnt_zero ? grant_q : fifo_q[rd_ptr_q];
    assign underflow_set = i_pkt_compared && cnt_zero && !accept;

    // Outstanding count: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (accept && !pop)
            count_d = count_q + 4'd1;
        else if (pop && !accept)
            count_d = count_q - 4'd1;
    end

    // Completion pulse and pop pulse decode to one-hot per requester.
    always_comb begin
        done_d     = '0;
        o_req_read = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (pop && (pop_idx == IDXW'(n)))
                done_d[n] = 1'b1;
            if ((state_q == S_FETCH) && (grant_q == IDXW'(n)))
                o_req_read[n] = 1'b1;
        end
    end

    // Control state, pointers, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            done_q      <= '0;
            underflow_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            if (state_q == S_LOAD) begin
                addr_q <= i_req_addr[grant_q*TGT_ADDR_WIDTH +: TGT_ADDR_WIDTH];
                len_q  <= i_req_len[grant_q*8 +: 8];
            end
            if (underflow_set)
                underflow_q <= 1'b1;
            if (fifo_wr)
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fifo_rd)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && fifo_wr)
            fifo_q[wr_ptr_q] <= grant_q;
    end

    assign o_xact_avail  = (state_q == S_OFFER);
    assign o_xact_addr   = addr_q;
    assign o_xact_len    = len_q;
    assign o_req_done    = done_q;
    assign o_outstanding = count_q;
    assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_axi_xact_arb.sv
// Scoreboard bench for axi_xact_arb (NUM_REQ=2, MAX_OUTSTANDING=2).
// Stimulus pushes expected grants, offers and completions into queues;
// independent monitors pop and compare whenever the DUT presents them.
module tb_axi_xact_arb;

    localparam int NR = 2;
    localparam int AW = 28;
    localparam int MO = 2;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [NR-1:0]   i_req_avail;
    logic [NR*AW-1:0] i_req_addr;
    logic [NR*8-1:0] i_req_len;
    logic [NR-1:0]   o_req_read;
    logic            o_xact_avail;
    logic            i_xact_read;
    logic [AW-1:0]   o_xact_addr;
    logic [7:0]      o_xact_len;
    logic            i_pkt_compared;
    logic [NR-1:0]   o_req_done;
    logic [3:0]      o_outstanding;
    logic            o_underflow;

    axi_xact_arb #(.NUM_REQ(NR), .TGT_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_avail    (i_req_avail),
        .i_req_addr     (i_req_addr),
        .i_req_len      (i_req_len),
        .o_req_read     (o_req_read),
        .o_xact_avail   (o_xact_avail),
        .i_xact_read    (i_xact_read),
        .o_xact_addr    (o_xact_addr),
        .o_xact_len     (o_xact_len),
        .i_pkt_compared (i_pkt_compared),
        .o_req_done     (o_req_done),
        .o_outstanding  (o_outstanding),
        .o_underflow    (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  q_grant [$];
    logic [35:0] q_xact  [$];
    logic [1:0]  q_done  [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requester model: item k (k = pops so far) is visible the cycle after
    // the k-th pop. req0: addr 0x100+0x10*(k-1), len 3+(k-1);
    // req1: addr 0x2000+0x10*(k-1), len 7+(k-1).
    int rcnt [NR] = '{0, 0};
    always @(posedge i_clk)
        for (int n = 0; n < NR; n++)
            if (o_req_read[n]) rcnt[n] <= rcnt[n] + 1;

    always_comb begin
        i_req_addr = {AW'(32'h2000 + 32'h10 * (rcnt[1] - 1)), AW'(32'h100 + 32'h10 * (rcnt[0] - 1))};
        i_req_len  = {8'(7 + rcnt[1] - 1), 8'(3 + rcnt[0] - 1)};
    end

    // Grant monitor.
    always @(negedge i_clk) begin
        if (o_req_read != '0) begin
            if (q_grant.size() == 0) chk("unexpected_grant", 64'(o_req_read), 64'd0);
            else                     chk("grant", 64'(o_req_read), 64'(q_grant.pop_front()));
        end
    end

    // Offer monitor: compares address/length on each new offer.
    logic prev_av = 1'b0;
    always @(negedge i_clk) begin
        if (o_xact_avail && !prev_av) begin
            if (q_xact.size() == 0) chk("unexpected_offer", 64'd1, 64'd0);
            else                    chk("offer", 64'({o_xact_addr, o_xact_len}), 64'(q_xact.pop_front()));
        end
        prev_av = o_xact_avail;
    end

    // Completion monitor.
    always @(negedge i_clk) begin
        if (o_req_done != '0) begin
            if (q_done.size() == 0) chk("unexpected_done", 64'(o_req_done), 64'd0);
            else                    chk("done", 64'(o_req_done), 64'(q_done.pop_front()));
        end
    end

    task automatic wait_read();
        for (int i = 0; i < 40 && o_req_read == '0; i++) @(negedge i_clk);
        if (o_req_read == '0) chk("timeout_read", 64'd0, 64'd1);
    endtask

    task automatic wait_offer();
        for (int i = 0; i < 40 && !o_xact_avail; i++) @(negedge i_clk);
        if (!o_xact_avail) chk("timeout_offer", 64'd0, 64'd1);
    endtask

    task automatic offer_accept();
        wait_offer();
        i_xact_read = 1'b1;
        @(negedge i_clk);
        i_xact_read = 1'b0;
    endtask

    task automatic compare();
        i_pkt_compared = 1'b1;
        @(negedge i_clk);
        i_pkt_compared = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    int nreads;
    int navail;

    initial begin
        i_reset        = 1'b1;
        i_req_avail    = '0;
        i_xact_read    = 1'b0;
        i_pkt_compared = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_read",  64'(o_req_read), 64'd0);
        chk("rst_avail", 64'(o_xact_avail), 64'd0);
        chk("rst_done",  64'(o_req_done), 64'd0);
        chk("rst_cnt",   64'(o_outstanding), 64'd0);
        chk("rst_uflow", 64'(o_underflow), 64'd0);
        chk("rst_addr",  64'(o_xact_addr), 64'd0);
        chk("rst_len",   64'(o_xact_len), 64'd0);
        i_reset = 1'b0;

        // Single requester 0: 0x100/3, offer two cycles after the pop.
        q_grant.push_back(2'b01);
        q_xact.push_back({28'h100, 8'd3});
        q_done.push_back(2'b01);
        i_req_avail = 2'b01;
        wait_read();
        i_req_avail = 2'b00;
        @(negedge i_clk); chk("t1_avail_load", 64'(o_xact_avail), 64'd0);
        @(negedge i_clk); chk("t1_avail_offer", 64'(o_xact_avail), 64'd1);
        offer_accept();
        chk("t1_cnt_after_accept", 64'(o_outstanding), 64'd1);
        chk("t1_avail_dropped", 64'(o_xact_avail), 64'd0);
        compare();
        chk("t1_done_next_cycle", 64'(o_req_done), 64'd1);
        chk("t1_cnt_after_cmp", 64'(o_outstanding), 64'd0);
        @(negedge i_clk); chk("t1_done_one_cycle", 64'(o_req_done), 64'd0);

        // Both available, immediate accept and compare: 0,1,0,1.
        do_reset();
        q_grant.push_back(2'b01); q_xact.push_back({28'h110,  8'd4}); q_done.push_back(2'b01);
        q_grant.push_back(2'b10); q_xact.push_back({28'h2000, 8'd7}); q_done.push_back(2'b10);
        q_grant.push_back(2'b01); q_xact.push_back({28'h120,  8'd5}); q_done.push_back(2'b01);
        q_grant.push_back(2'b10); q_xact.push_back({28'h2010, 8'd8}); q_done.push_back(2'b10);
        i_req_avail = 2'b11;
        for (int k = 0; k < 4; k++) begin
            offer_accept();
            if (k == 3) i_req_avail = 2'b00;
            compare();
        end
        repeat (2) @(negedge i_clk);
        chk("t2_cnt", 64'(o_outstanding), 64'd0);

        // Limit of two outstanding: stall until a compare frees a slot.
        q_grant.push_back(2'b01); q_xact.push_back({28'h130,  8'd6});
        q_grant.push_back(2'b10); q_xact.push_back({28'h2020, 8'd9});
        i_req_avail = 2'b11;
        offer_accept();
        offer_accept();
        nreads = 0;
        navail = 0;
        repeat (8) begin
            @(negedge i_clk);
            if (o_req_read != '0) nreads++;
            if (o_xact_avail) navail++;
        end
        chk("t3_stall_reads", 64'(nreads), 64'd0);
        chk("t3_stall_offers", 64'(navail), 64'd0);
        chk("t3_cnt_full", 64'(o_outstanding), 64'd2);
        q_done.push_back(2'b01);
        q_grant.push_back(2'b01); q_xact.push_back({28'h140, 8'd7});
        compare();
        chk("t3_cnt_after_cmp", 64'(o_outstanding), 64'd1);
        wait_read();
        i_req_avail = 2'b00;
        wait_offer();

        // Accept and compare in the same cycle at count 1.
        q_done.push_back(2'b10);
        i_xact_read    = 1'b1;
        i_pkt_compared = 1'b1;
        @(negedge i_clk);
        i_xact_read    = 1'b0;
        i_pkt_compared = 1'b0;
        chk("t4_cnt_same", 64'(o_outstanding), 64'd1);
        chk("t4_done_oldest", 64'(o_req_done), 64'd2);
        q_done.push_back(2'b01);
        compare();
        chk("t4_cnt_drain", 64'(o_outstanding), 64'd0);

        // Compare with nothing outstanding; stray accept outside OFFER.
        compare();
        chk("t5_uflow", 64'(o_underflow), 64'd1);
        chk("t5_cnt", 64'(o_outstanding), 64'd0);
        i_xact_read = 1'b1;
        @(negedge i_clk);
        i_xact_read = 1'b0;
        @(negedge i_clk);
        chk("t5_stray_accept_cnt", 64'(o_outstanding), 64'd0);
        repeat (3) @(negedge i_clk);
        chk("t5_uflow_sticky", 64'(o_underflow), 64'd1);

        // Reset during OFFER with transactions outstanding.
        q_grant.push_back(2'b10); q_xact.push_back({28'h2030, 8'd10});
        q_grant.push_back(2'b01); q_xact.push_back({28'h150,  8'd8});
        i_req_avail = 2'b11;
        offer_accept();
        offer_accept();
        chk("t6_cnt_full", 64'(o_outstanding), 64'd2);
        i_req_avail = 2'b01;
        q_done.push_back(2'b10);
        q_grant.push_back(2'b01); q_xact.push_back({28'h160, 8'd9});
        compare();
        wait_offer();
        chk("t6_cnt_in_offer", 64'(o_outstanding), 64'd1);
        i_reset     = 1'b1;
        i_req_avail = 2'b00;
        @(negedge i_clk);
        chk("t6_rst_read",  64'(o_req_read), 64'd0);
        chk("t6_rst_avail", 64'(o_xact_avail), 64'd0);
        chk("t6_rst_done",  64'(o_req_done), 64'd0);
        chk("t6_rst_cnt",   64'(o_outstanding), 64'd0);
        chk("t6_rst_uflow", 64'(o_underflow), 64'd0);
        chk("t6_rst_addr",  64'(o_xact_addr), 64'd0);
        chk("t6_rst_len",   64'(o_xact_len), 64'd0);
        i_reset = 1'b0;
        compare();
        chk("t6_discarded_uflow", 64'(o_underflow), 64'd1);
        chk("t6_discarded_cnt", 64'(o_outstanding), 64'd0);
        q_grant.push_back(2'b01); q_xact.push_back({28'h170, 8'd10});
        i_req_avail = 2'b11;
        offer_accept();
        i_req_avail = 2'b00;
        q_done.push_back(2'b01);
        compare();
        chk("t6_cnt_end", 64'(o_outstanding), 64'd0);

        repeat (5) @(negedge i_clk);
        chk("grant_queue_empty", 64'(q_grant.size()), 64'd0);
        chk("offer_queue_empty", 64'(q_xact.size()), 64'd0);
        chk("done_queue_empty",  64'(q_done.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
